// File: rtl/uart_i2c_pkg.sv
// uart_i2c_pkg: shared parser states, mode encodings and error codes for the UART-to-I2C path
package uart_i2c_pkg;
  typedef enum logic [2:0] {
    S_IDLE, S_GET_MODE, S_GET_ADDR, S_GET_D0, S_GET_D1, S_COMMIT, S_WAIT_SPACE
  } parser_state_t;
  localparam logic [1:0] MODE_PTR = 2'b00;
  localparam logic [1:0] MODE_RD2 = 2'b01;
  localparam logic [1:0] MODE_WR1 = 2'b10;
  localparam logic [1:0] MODE_WR2 = 2'b11;
  localparam logic [1:0] ERR_MODE = 2'd1;
  localparam logic [1:0] ERR_TIMEOUT = 2'd2;
  localparam logic [1:0] ERR_OVERRUN = 2'd3;
  function automatic int unsigned data_bytes(input logic [1:0] m);
    return (m == MODE_PTR || m == MODE_RD2) ? 0 : (m == MODE_WR1) ? 1 : 2;
  endfunction
endpackage

// File: rtl/byte_timeout_timer.sv
// byte_timeout_timer: reloadable down-counter that flags expiry when it reaches zero while enabled
module byte_timeout_timer #(
  parameter int TW = 17,
  parameter logic [TW-1:0] LOAD = '1
) (
  input  logic clk,
  input  logic reset,
  input  logic i_clear,
  input  logic i_en,
  output logic o_expire
);
  logic [TW-1:0] r_cnt;
  always_ff @(posedge clk or negedge reset)
    if (!reset) r_cnt <= '0;
    else if (i_clear) r_cnt <= LOAD;
    else if (i_en && r_cnt != '0) r_cnt <= r_cnt - TW'(1);
  assign o_expire = i_en && (r_cnt == '0);
endmodule

// File: rtl/uart_cmd_parser.sv
// uart_cmd_parser: assembles framed UART commands and commits them to four aligned instruction FIFOs
module uart_cmd_parser
  import uart_i2c_pkg::*;
#(
  parameter logic [7:0] SYNC_BYTE = 8'hA5,
  parameter int TIMEOUT_CYCLES = 100000,
  parameter int TW = 17
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  input  logic        buffers_full,
  output logic        wr_opbuffer,
  output logic        wr_addrbuffer,
  output logic        wr_databuffer1,
  output logic        wr_databuffer2,
  output logic [7:0]  mode,
  output logic [7:0]  addr_pointer,
  output logic [15:0] wr_data,
  output logic        busy,
  output logic        err_valid,
  output logic [1:0]  err_code
);
  parser_state_t r_state;
  logic          r_wr;
  logic [7:0]    r_mode;
  logic [7:0]    r_addr;
  logic [15:0]   r_wr_data;
  logic          r_err_valid;
  logic [1:0]    r_err_code;
  logic          w_run;
  logic          w_clear;
  logic          w_expire;

  assign w_run = (r_state >= S_GET_MODE) && (r_state <= S_GET_D1);
  assign w_clear = rx_valid && (r_state == S_IDLE || w_run);

  byte_timeout_timer #(.TW(TW), .LOAD(TW'(TIMEOUT_CYCLES - 1))) u_timer (
    .clk      (clk),
    .reset    (reset),
    .i_clear  (w_clear),
    .i_en     (w_run),
    .o_expire (w_expire)
  );

  // The final byte of a frame either fires the strobes next cycle or parks in WAIT_SPACE.
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      r_state     <= S_IDLE;
      r_wr        <= 1'b0;
      r_mode      <= '0;
      r_addr      <= '0;
      r_wr_data   <= '0;
      r_err_valid <= 1'b0;
      r_err_code  <= '0;
    end else begin
      r_wr        <= 1'b0;
      r_err_valid <= 1'b0;
      if (w_expire && !rx_valid) begin
        r_err_valid <= 1'b1;
        r_err_code  <= ERR_TIMEOUT;
        r_state     <= S_IDLE;
      end else begin
        case (r_state)
          S_IDLE:
            if (rx_valid && rx_data == SYNC_BYTE) r_state <= S_GET_MODE;
          S_GET_MODE:
            if (rx_valid) begin
              if (|rx_data[7:2]) begin
                r_err_valid <= 1'b1;
                r_err_code  <= ERR_MODE;
                r_state     <= S_IDLE;
              end else begin
                r_mode    <= rx_data;
                r_wr_data <= '0;
                r_state   <= S_GET_ADDR;
              end
            end
          S_GET_ADDR:
            if (rx_valid) begin
              r_addr <= rx_data;
              if (data_bytes(r_mode[1:0]) != 0) r_state <= S_GET_D0;
              else begin
                r_wr    <= !buffers_full;
                r_state <= buffers_full ? S_WAIT_SPACE : S_COMMIT;
              end
            end
          S_GET_D0:
            if (rx_valid) begin
              r_wr_data[7:0] <= rx_data;
              if (data_bytes(r_mode[1:0]) == 2) r_state <= S_GET_D1;
              else begin
                r_wr    <= !buffers_full;
                r_state <= buffers_full ? S_WAIT_SPACE : S_COMMIT;
              end
            end
          S_GET_D1:
            if (rx_valid) begin
              r_wr_data[15:8] <= rx_data;
              r_wr            <= !buffers_full;
              r_state         <= buffers_full ? S_WAIT_SPACE : S_COMMIT;
            end
          S_COMMIT:
            r_state <= S_IDLE;
          S_WAIT_SPACE: begin
            if (rx_valid) begin
              r_err_valid <= 1'b1;
              r_err_code  <= ERR_OVERRUN;
            end
            if (!buffers_full) begin
              r_wr    <= 1'b1;
              r_state <= S_COMMIT;
            end
          end
          default:
            r_state <= S_IDLE;
        endcase
      end
    end

  assign wr_opbuffer    = r_wr;
  assign wr_addrbuffer  = r_wr;
  assign wr_databuffer1 = r_wr;
  assign wr_databuffer2 = r_wr;
  assign mode           = r_mode;
  assign addr_pointer   = r_addr;
  assign wr_data        = r_wr_data;
  assign busy           = (r_state != S_IDLE);
  assign err_valid      = r_err_valid;
  assign err_code       = r_err_code;
endmodule
